// File: rtl/alu_pkg.sv
// alu_pkg: shared ALUOp, slice-select, funct3 and forwarding-select encodings
package alu_pkg;
  localparam logic [1:0] ALUOP_MEM    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_ARITH  = 2'b10;
  localparam logic [1:0] ALUOP_RSVD   = 2'b11;
  localparam logic [1:0] SEL_AND  = 2'b00;
  localparam logic [1:0] SEL_OR   = 2'b01;
  localparam logic [1:0] SEL_ADD  = 2'b10;
  localparam logic [1:0] SEL_LESS = 2'b11;
  localparam logic [2:0] FUNCT3_ADD = 3'b000;
  localparam logic [2:0] FUNCT3_AND = 3'b111;
  localparam logic [2:0] FUNCT3_OR  = 3'b110;
  localparam logic [2:0] FUNCT3_SLT = 3'b010;
  localparam logic [1:0] FWD_REG   = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;
endpackage

// File: rtl/alu_ctrl_decode.sv
// alu_ctrl_decode: ALUOp/funct to 1-bit slice control {ainvert, binvert, cin, op} plus illegal flag
module alu_ctrl_decode
  import alu_pkg::*;
(
  input  logic       alusrc,
  input  logic [1:0] aluop,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  output logic       ainvert,
  output logic       binvert,
  output logic       cin,
  output logic [1:0] op,
  output logic       illegal
);
  logic arith;
  logic sub;
  // subtract for branches, R-type sub and slt; addi ignores bit 30
  always_comb begin
    arith   = aluop == ALUOP_ARITH;
    sub     = aluop == ALUOP_BRANCH
           || (arith && funct3 == FUNCT3_ADD && funct7b5 && !alusrc)
           || (arith && funct3 == FUNCT3_SLT);
    op      = !arith ? SEL_ADD :
              funct3 == FUNCT3_AND ? SEL_AND :
              funct3 == FUNCT3_OR  ? SEL_OR  :
              funct3 == FUNCT3_SLT ? SEL_LESS : SEL_ADD;
    illegal = aluop == ALUOP_RSVD
           || (arith && funct3 != FUNCT3_ADD && funct3 != FUNCT3_AND
                     && funct3 != FUNCT3_OR  && funct3 != FUNCT3_SLT);
    ainvert = 1'b0;
    binvert = sub;
    cin     = sub;
  end
endmodule

// File: rtl/id_ex_alu_issue.sv
// id_ex_alu_issue: ID/EX register with ALU slice-control decode, stall/flush; ID_EX_FWD_EN adds operand forwarding
module id_ex_alu_issue
  import alu_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int REGW = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            flush,
`ifdef ID_EX_FWD_EN
  input  logic [1:0]      fwd_a_sel,
  input  logic [1:0]      fwd_b_sel,
  input  logic [XLEN-1:0] exmem_result,
  input  logic [XLEN-1:0] memwb_result,
`endif
  input  logic            id_valid,
  input  logic [1:0]      id_aluop,
  input  logic [2:0]      id_funct3,
  input  logic            id_funct7b5,
  input  logic            id_alusrc,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [REGW-1:0] id_rd,
  input  logic            id_regwrite,
  input  logic            id_memread,
  input  logic            id_memwrite,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_a,
  output logic [XLEN-1:0] ex_b,
  output logic [XLEN-1:0] ex_rs2_data,
  output logic            ex_ainvert,
  output logic            ex_binvert,
  output logic            ex_cin,
  output logic [1:0]      ex_op,
  output logic [REGW-1:0] ex_rd,
  output logic            ex_regwrite,
  output logic            ex_memread,
  output logic            ex_memwrite,
  output logic            ex_illegal
);
  logic            dec_ainvert, dec_binvert, dec_cin, dec_illegal;
  logic [1:0]      dec_op;
  logic            valid_d, valid_q, ainvert_d, ainvert_q, binvert_d, binvert_q, cin_d, cin_q;
  logic            regwrite_d, regwrite_q, memread_d, memread_q, memwrite_d, memwrite_q;
  logic            illegal_d, illegal_q, alusrc_d, alusrc_q;
  logic [1:0]      op_d, op_q;
  logic [REGW-1:0] rd_d, rd_q;
  logic [XLEN-1:0] a_d, a_q, b_d, b_q, rs2_d, rs2_q;
  logic            bubble, load;

  alu_ctrl_decode u_dec (
    .alusrc   (id_alusrc),
    .aluop    (id_aluop),
    .funct3   (id_funct3),
    .funct7b5 (id_funct7b5),
    .ainvert  (dec_ainvert),
    .binvert  (dec_binvert),
    .cin      (dec_cin),
    .op       (dec_op),
    .illegal  (dec_illegal)
  );

  // flush beats stall; an invalid ID slot loads the same bubble as flush
  always_comb begin
    bubble     = flush || (!stall && !id_valid);
    load       = !flush && !stall && id_valid;
    valid_d    = bubble ? 1'b0 : load ? 1'b1 : valid_q;
    ainvert_d  = bubble ? 1'b0 : load ? dec_ainvert : ainvert_q;
    binvert_d  = bubble ? 1'b0 : load ? dec_binvert : binvert_q;
    cin_d      = bubble ? 1'b0 : load ? dec_cin : cin_q;
    op_d       = bubble ? SEL_AND : load ? dec_op : op_q;
    illegal_d  = bubble ? 1'b0 : load ? dec_illegal : illegal_q;
    regwrite_d = bubble ? 1'b0 : load ? id_regwrite : regwrite_q;
    memread_d  = bubble ? 1'b0 : load ? id_memread : memread_q;
    memwrite_d = bubble ? 1'b0 : load ? id_memwrite : memwrite_q;
    alusrc_d   = bubble ? 1'b0 : load ? id_alusrc : alusrc_q;
    rd_d       = bubble ? '0 : load ? id_rd : rd_q;
    a_d        = bubble ? '0 : load ? id_rs1_data : a_q;
    b_d        = bubble ? '0 : load ? (id_alusrc ? id_imm : id_rs2_data) : b_q;
    rs2_d      = bubble ? '0 : load ? id_rs2_data : rs2_q;
  end

  // pipeline register with synchronous reset to all zeros
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q    <= 1'b0;
      ainvert_q  <= 1'b0;
      binvert_q  <= 1'b0;
      cin_q      <= 1'b0;
      op_q       <= SEL_AND;
      illegal_q  <= 1'b0;
      regwrite_q <= 1'b0;
      memread_q  <= 1'b0;
      memwrite_q <= 1'b0;
      alusrc_q   <= 1'b0;
      rd_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      rs2_q      <= '0;
    end else begin
      valid_q    <= valid_d;
      ainvert_q  <= ainvert_d;
      binvert_q  <= binvert_d;
      cin_q      <= cin_d;
      op_q       <= op_d;
      illegal_q  <= illegal_d;
      regwrite_q <= regwrite_d;
      memread_q  <= memread_d;
      memwrite_q <= memwrite_d;
      alusrc_q   <= alusrc_d;
      rd_q       <= rd_d;
      a_q        <= a_d;
      b_q        <= b_d;
      rs2_q      <= rs2_d;
    end
  end

  assign ex_valid    = valid_q;
  assign ex_ainvert  = ainvert_q;
  assign ex_binvert  = binvert_q;
  assign ex_cin      = cin_q;
  assign ex_op       = op_q;
  assign ex_illegal  = illegal_q;
  assign ex_regwrite = regwrite_q;
  assign ex_memread  = memread_q;
  assign ex_memwrite = memwrite_q;
  assign ex_rd       = rd_q;

`ifdef ID_EX_FWD_EN
  logic [XLEN-1:0] fwd_b;
  // select 11 falls back to the registered operand
  always_comb begin
    ex_a        = fwd_a_sel == FWD_EXMEM ? exmem_result : fwd_a_sel == FWD_MEMWB ? memwb_result : a_q;
    fwd_b       = fwd_b_sel == FWD_EXMEM ? exmem_result : fwd_b_sel == FWD_MEMWB ? memwb_result : rs2_q;
    ex_b        = alusrc_q ? b_q : fwd_b;
    ex_rs2_data = fwd_b;
  end
`else
  logic unused_alusrc;
  assign unused_alusrc = alusrc_q;
  assign ex_a          = a_q;
  assign ex_b          = b_q;
  assign ex_rs2_data   = rs2_q;
`endif
endmodule
